ps2_ctrl: RTL and testbench

PS2_CTRL -- requirements
Module: ps2_ctrl

---
 rtl/ps2_ctrl_pkg.sv | 32 +++
 rtl/ps2_tx.sv | 105 ++++++++++
 rtl/ps2_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ps2_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_ctrl_pkg.sv
// Shared definitions for the PS/2 controller: register map, status/control bit
// positions and the encoding of the host-to-device transmit sequencer.
package ps2_ctrl_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_TX     = 3'd3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_TX_BUSY   = 3;
  localparam int ST_TX_ERR    = 4;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_IRQ_EN  = 0;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_INHIBIT,
    TX_RTS,
    TX_DATA,
    TX_ACK
  } tx_state_e;

  // Odd parity: the bit that makes the total count of ones in byte+parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmit sequencer; only compiled when PS2_TX_EN is defined.
// Inputs kclk_fall/kdata_s are already synchronized to clk by the parent.
`ifdef PS2_TX_EN
module ps2_tx
  import ps2_ctrl_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       kclk_fall,
  input  logic       kdata_s,
  output logic       kclk_oe,
  output logic       kdata_oe,
  output logic       busy,
  output logic       err
);
  localparam int INHIBIT_CYCLES = CLK_HZ / 10000;
  localparam int TIMEOUT_CYCLES = CLK_HZ / 500;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    idx_q, idx_d;
  logic          kdata_oe_q, kdata_oe_d;
  logic          err_q, err_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    idx_d      = idx_q;
    kdata_oe_d = kdata_oe_q;
    err_d      = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (start) begin
          frame_d = {1'b1, odd_parity(tx_byte), tx_byte};
          cnt_d   = '0;
          idx_d   = '0;
          state_d = TX_INHIBIT;
        end
      end
      TX_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          cnt_d      = '0;
          kdata_oe_d = 1'b1;
          state_d    = TX_RTS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_RTS, TX_DATA, TX_ACK: begin
        // One shared timer covers the whole device-clocked part of the frame.
        cnt_d = cnt_q + CW'(1);
        if (kclk_fall) begin
          if (state_q == TX_ACK) begin
            err_d      = kdata_s;
            kdata_oe_d = 1'b0;
            state_d    = TX_IDLE;
          end else begin
            kdata_oe_d = ~frame_q[idx_q];
            idx_d      = idx_q + 4'd1;
            state_d    = (idx_q == 4'd9) ? TX_ACK : TX_DATA;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d      = 1'b1;
          kdata_oe_d = 1'b0;
          state_d    = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= TX_IDLE;
      cnt_q      <= '0;
      frame_q    <= '0;
      idx_q      <= '0;
      kdata_oe_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      kdata_oe_q <= kdata_oe_d;
      err_q      <= err_d;
    end
  end

  assign kclk_oe  = (state_q == TX_INHIBIT);
  assign kdata_oe = kdata_oe_q;
  assign busy     = (state_q != TX_IDLE);
  assign err      = err_q;

endmodule
`endif

// File: rtl/ps2_ctrl.sv
// PS/2 controller: register interface, receive FIFO with overflow flag, level irq.
// Define PS2_TX_EN to build in the host-to-device transmitter (ps2_tx).
module ps2_ctrl
  import ps2_ctrl_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        irq,
  input  logic        kclk,
  input  logic        kdata,
  output logic        kclk_oe,
  output logic        kdata_oe
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q, irq_d, tx_err_q, tx_err_d;
  logic          kclk_meta_q, kclk_s_q, kclk_prev_q, kdata_meta_q, kdata_s_q;
  logic          empty, full, push, pop, kclk_fall;
  logic          tx_busy, tx_err_pulse;
  logic [7:0]    tx_last, head_byte;
  logic [31:0]   status;
  logic          unused_bits;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign pop       = we && (a == ADDR_DATA) && !empty;
  // A pop in the same cycle frees the slot the write pointer points at.
  assign push      = rx_valid && (!full || pop);
  assign head_byte = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign kclk_fall = kclk_prev_q && !kclk_s_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    tx_err_d = tx_err_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (we && (a == ADDR_STATUS)) begin
      if (d[ST_OVF])    ovf_d    = 1'b0;
      if (d[ST_TX_ERR]) tx_err_d = 1'b0;
    end
    // A new event in the same cycle as a software clear wins, so it is never lost.
    if (rx_valid && !push) ovf_d    = 1'b1;
    if (tx_err_pulse)      tx_err_d = 1'b1;
    if (we && (a == ADDR_CTRL)) irq_en_d = d[CTRL_IRQ_EN];
    irq_d = irq_en_q && !empty;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
      tx_err_q     <= 1'b0;
      kclk_meta_q  <= 1'b1;
      kclk_s_q     <= 1'b1;
      kclk_prev_q  <= 1'b1;
      kdata_meta_q <= 1'b1;
      kdata_s_q    <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
      tx_err_q     <= tx_err_d;
      kclk_meta_q  <= kclk;
      kclk_s_q     <= kclk_meta_q;
      kclk_prev_q  <= kclk_s_q;
      kdata_meta_q <= kdata;
      kdata_s_q    <= kdata_meta_q;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_byte;
  end

  always_comb begin
    status                      = '0;
    status[ST_EMPTY]            = empty;
    status[ST_FULL]             = full;
    status[ST_OVF]              = ovf_q;
    status[ST_TX_BUSY]          = tx_busy;
    status[ST_TX_ERR]           = tx_err_q;
    status[ST_COUNT_LSB +: 8]   = 8'(count_q);
  end

  always_comb begin
    spo = '0;
    case (a)
      ADDR_DATA:   spo = {23'b0, !empty, head_byte};
      ADDR_STATUS: spo = status;
      ADDR_CTRL:   spo = {31'b0, irq_en_q};
      ADDR_TX:     spo = {24'b0, tx_last};
      default:     spo = '0;
    endcase
  end

  assign irq = irq_q;

`ifdef PS2_TX_EN
  logic       tx_start;
  logic [7:0] tx_last_q, tx_last_d;

  // Writes while a frame is in flight are dropped without flagging an error.
  assign tx_start  = we && (a == ADDR_TX) && !tx_busy;
  assign tx_last_d = tx_start ? d[7:0] : tx_last_q;
  assign tx_last   = tx_last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_last_q <= '0;
    else      tx_last_q <= tx_last_d;
  end

  ps2_tx #(
    .CLK_HZ(CLK_HZ)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (tx_start),
    .tx_byte  (d[7:0]),
    .kclk_fall(kclk_fall),
    .kdata_s  (kdata_s_q),
    .kclk_oe  (kclk_oe),
    .kdata_oe (kdata_oe),
    .busy     (tx_busy),
    .err      (tx_err_pulse)
  );
`else
  localparam int unused_clk_hz = CLK_HZ;
  assign tx_busy      = 1'b0;
  assign tx_err_pulse = 1'b0;
  assign tx_last      = 8'h00;
  assign kclk_oe      = 1'b0;
  assign kdata_oe     = 1'b0;
`endif

  assign unused_bits = ^{d, kclk_fall, kdata_s_q};

endmodule

// File: tb/tb_ps2_ctrl.sv
// Self-checking bench for ps2_ctrl: directed FIFO/irq/reset scenarios plus randomized
// traffic against a queue-based model; transmitter scenarios run when PS2_TX_EN is defined.
module tb_ps2_ctrl;
  localparam int DEPTH     = 16;
  localparam int TB_CLK_HZ = 5_000_000;  // scaled so the 2 ms timeout stays short

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        irq;
  logic        kclk, kdata;
  logic        kclk_oe, kdata_oe;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [7:0] fifo_m[$];
  bit         ovf_m, irq_en_m, irq_m, tx_busy_m, tx_err_m;
  logic [7:0] tx_last_m;

  ps2_ctrl #(
    .CLK_HZ    (TB_CLK_HZ),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .d       (d),
    .we      (we),
    .spo     (spo),
    .rx_valid(rx_valid),
    .rx_byte (rx_byte),
    .irq     (irq),
    .kclk    (kclk),
    .kdata   (kdata),
    .kclk_oe (kclk_oe),
    .kdata_oe(kdata_oe)
  );

  always #10 clk = ~clk;

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_status();
    int n;
    n = fifo_m.size();
    return (32'(n % 256) << 8) | (32'(tx_err_m) << 4) | (32'(tx_busy_m) << 3) |
           (32'(ovf_m) << 2) | (32'(n == DEPTH) << 1) | 32'(n == 0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] adr);
    logic [31:0] r;
    r = 32'h0;
    case (adr)
      3'd0: if (fifo_m.size() != 0) r = 32'h100 | 32'(fifo_m[0]);
      3'd1: r = exp_status();
      3'd2: r = 32'(irq_en_m);
      3'd3: r = 32'(tx_last_m);
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    fifo_m.delete();
    ovf_m = 0; irq_en_m = 0; irq_m = 0; tx_busy_m = 0; tx_err_m = 0; tx_last_m = 8'h00;
  endtask

  // Called at a negedge: drives one cycle of inputs, advances the model, returns at the next negedge.
  task automatic step(input bit psh, input logic [7:0] pb, input bit wr, input logic [2:0] wa,
                      input logic [31:0] wd);
    rx_valid = psh; rx_byte = pb; we = wr; a = wa; d = wd;
    irq_m = irq_en_m && (fifo_m.size() != 0);
    if (wr && wa == 3'd0 && fifo_m.size() != 0) void'(fifo_m.pop_front());
    if (wr && wa == 3'd1 && wd[2]) ovf_m = 0;
    if (wr && wa == 3'd1 && wd[4]) tx_err_m = 0;
    if (wr && wa == 3'd2) irq_en_m = wd[0];
`ifdef PS2_TX_EN
    if (wr && wa == 3'd3 && !tx_busy_m) begin
      tx_last_m = wd[7:0];
      tx_busy_m = 1;
    end
`endif
    if (psh) begin
      if (fifo_m.size() < DEPTH) fifo_m.push_back(pb);
      else ovf_m = 1;
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    we       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 3'd0, 32'h0);
  endtask

  task automatic rd(input string tag, input logic [2:0] adr);
    a = adr;
    #1;
    check(tag, spo, exp_rd(adr));
  endtask

`ifdef PS2_TX_EN
  localparam int INH = TB_CLK_HZ / 10000;
  localparam int TMO = TB_CLK_HZ / 500;

  // Device pulls the clock low for a few cycles, presenting dbit on the data line.
  task automatic dev_fall(input logic dbit);
    kdata = dbit;
    kclk  = 1'b0;
    idle(4);
    kclk  = 1'b1;
    idle(4);
  endtask
`endif

  initial begin
    rst = 1'b0; a = 3'd0; d = 32'h0; we = 1'b0;
    rx_valid = 1'b0; rx_byte = 8'h00; kclk = 1'b1; kdata = 1'b1;
    model_reset();

    // Reset state
    @(negedge clk);
    rd("reset_status", 3'd1);
    check("reset_irq", irq, 1'b0);
    check("reset_oe", {kclk_oe, kdata_oe}, 2'b00);
    rd("reset_ctrl", 3'd2);
    @(negedge clk);
    rst = 1'b1;
    idle(1);

    // Three-byte scancode, interrupt enabled
    step(1'b0, 8'h00, 1'b1, 3'd2, 32'h1);
    step(1'b1, 8'h1C, 1'b0, 3'd0, 32'h0);
    step(1'b1, 8'hF0, 1'b0, 3'd0, 32'h0);
    step(1'b1, 8'h1C, 1'b0, 3'd0, 32'h0);
    check("irq_set", irq, irq_m);
    check("irq_set_const", irq, 1'b1);
    rd("head_peek", 3'd0);
    check("head_peek_const", spo, 32'h11C);
    rd("head_not_popped", 3'd0);
    rd("count3", 3'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 3'd0, 32'h0);
      rd("pop_head", 3'd0);
      rd("pop_status", 3'd1);
      check("pop_irq", irq, irq_m);
    end
    check("irq_lag_after_last_pop", irq, 1'b1);
    idle(1);
    check("irq_clear", irq, 1'b0);
    step(1'b0, 8'h00, 1'b1, 3'd0, 32'h0);
    rd("pop_empty_noop", 3'd1);

    // Overflow: one more byte than the FIFO holds
    for (int i = 0; i <= DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 3'd0, 32'h0);
    rd("full_status", 3'd1);
    check("full_status_const", spo, 32'h1006);
    rd("full_head", 3'd0);
    step(1'b0, 8'h00, 1'b1, 3'd1, 32'h4);
    rd("ovf_cleared", 3'd1);
    check("ovf_cleared_const", spo, 32'h1002);

    // Push and pop on a full FIFO in one cycle
    step(1'b1, 8'hAA, 1'b1, 3'd0, 32'h0);
    rd("full_pushpop_status", 3'd1);
    check("full_pushpop_count", spo[15:8], 8'd16);
    for (int i = 0; i < DEPTH - 1; i++) begin
      step(1'b0, 8'h00, 1'b1, 3'd0, 32'h0);
      rd("drain_head", 3'd0);
    end
    check("tail_is_aa", spo, 32'h1AA);
    step(1'b0, 8'h00, 1'b1, 3'd0, 32'h0);
    rd("drained", 3'd1);

`ifndef PS2_TX_EN
    // Transmit register is inert in this build
    step(1'b0, 8'h00, 1'b1, 3'd3, 32'h5A);
    rd("tx_reg_reads_zero", 3'd3);
    rd("tx_status_zero", 3'd1);
    check("tx_oe_tied", {kclk_oe, kdata_oe}, 2'b00);
`endif

    // Randomized register traffic with line noise
    for (int i = 0; i < 400; i++) begin
      int          sel;
      int          push_pct;
      logic [2:0]  wa;
      logic [31:0] wd;
      push_pct = (i < 200) ? 70 : 30;
      sel = $urandom_range(0, 9);
      wa = (sel < 4) ? 3'd0 : (sel < 6) ? 3'd1 : (sel < 8) ? 3'd2 : 3'($urandom_range(4, 7));
      wd = $urandom;
      kclk  = 1'($urandom);
      kdata = 1'($urandom);
      step($urandom_range(0, 99) < push_pct, 8'($urandom), $urandom_range(0, 99) < 35, wa, wd);
      rd("rand_status", 3'd1);
      rd("rand_data", 3'd0);
      rd("rand_ctrl", 3'($urandom_range(2, 7)));
      check("rand_irq", irq, irq_m);
      check("rand_oe", {kclk_oe, kdata_oe}, 2'b00);
    end
    kclk = 1'b1; kdata = 1'b1;
    while (fifo_m.size() != 0) step(1'b0, 8'h00, 1'b1, 3'd0, 32'h0);
    step(1'b0, 8'h00, 1'b1, 3'd1, 32'h14);
    rd("rand_drained", 3'd1);

`ifdef PS2_TX_EN
    begin
      int         n;
      logic [7:0] txv;
      int         exp_bit;
      // Full frame 0xED with a cooperating device
      txv = 8'hED;
      step(1'b0, 8'h00, 1'b1, 3'd3, 32'(txv));
      rd("tx_busy", 3'd1);
      n = 0;
      while (kclk_oe === 1'b1 && n < INH + 10) begin
        n++;
        idle(1);
      end
      check("inhibit_len", n, INH);
      check("rts_lines", {kclk_oe, kdata_oe}, 2'b01);
      for (int i = 0; i < 10; i++) begin
        dev_fall(1'b1);
        if (i < 8)       exp_bit = int'((txv >> i) & 8'h1);
        else if (i == 8) exp_bit = ($countones(txv) % 2 == 0) ? 1 : 0;
        else             exp_bit = 1;
        check("tx_bit", 32'(!kdata_oe), 32'(exp_bit));
      end
      dev_fall(1'b0);
      kdata = 1'b1;
      tx_busy_m = 0;
      rd("tx_done_status", 3'd1);
      rd("tx_last", 3'd3);

      // Device never clocks: timeout, second write ignored
      step(1'b0, 8'h00, 1'b1, 3'd3, 32'h55);
      idle(INH);
      check("timeout_rts", {kclk_oe, kdata_oe}, 2'b01);
      step(1'b0, 8'h00, 1'b1, 3'd3, 32'h12);
      rd("busy_write_ignored", 3'd3);
      idle(TMO - 10);
      rd("still_busy", 3'd1);
      idle(20);
      tx_busy_m = 0;
      tx_err_m  = 1;
      rd("timeout_err", 3'd1);
      check("timeout_released", {kclk_oe, kdata_oe}, 2'b00);
      step(1'b0, 8'h00, 1'b1, 3'd1, 32'h10);
      rd("tx_err_cleared", 3'd1);

      // Start a frame and stop in the data phase with the data line pulled
      step(1'b0, 8'h00, 1'b1, 3'd3, 32'hA5);
      idle(INH);
      dev_fall(1'b1);
      dev_fall(1'b1);
      check("mid_data_driving", kdata_oe, 1'b1);
    end
`endif

    // Asynchronous reset in the middle of activity
    step(1'b0, 8'h00, 1'b1, 3'd2, 32'h1);
    step(1'b1, 8'h12, 1'b0, 3'd0, 32'h0);
    step(1'b1, 8'h34, 1'b0, 3'd0, 32'h0);
    #3;
    rst = 1'b0;
    #1;
    check("rst_kclk_oe", kclk_oe, 1'b0);
    check("rst_kdata_oe", kdata_oe, 1'b0);
    check("rst_irq_async", irq, 1'b0);
    model_reset();
    rd("rst_status", 3'd1);
    check("rst_status_const", spo, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    rd("post_rst_status", 3'd1);
    rd("post_rst_ctrl", 3'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
